// File: rtl/sap2_loader_pkg.sv
// Shared types for the SAP-2 UART program loader: FSM state enums and data width.
package sap2_loader_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_WAIT_LEN,
    LD_WAIT_DATA,
    LD_WRITE,
    LD_WAIT_SUM,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

endpackage

// File: rtl/sap2_uart_rx.sv
// UART 8N1 receiver: two-flop RXD synchronizer, start/data/stop FSM, LSB-first shifter.
// rx_valid / rx_ferr pulse for one cycle on the stop-bit sample.
module sap2_uart_rx
  import sap2_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_ferr
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic              sync1, sync2, sync_prev;
  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  tick;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              sample_start, sample_bit, sample_stop;

  assign sample_start = (state == RX_START) && (tick == HALF_LAST);
  assign sample_bit   = (state == RX_DATA)  && (tick == BIT_LAST);
  assign sample_stop  = (state == RX_STOP)  && (tick == BIT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (sync_prev && !sync2) state_next = RX_START;
      RX_START: if (sample_start) state_next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample_bit && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (sample_stop) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  assign rx_valid = sample_stop && sync2;
  assign rx_ferr  = sample_stop && !sync2;
  assign rx_byte  = shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      state     <= RX_IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      sync_prev <= sync2;
      state     <= state_next;
      // tick restarts on every state change and after each data-bit sample
      if (state != state_next || sample_bit)
        tick <= '0;
      else if (state != RX_IDLE)
        tick <= tick + CNT_W'(1);
      if (state == RX_IDLE)
        bit_idx <= '0;
      else if (sample_bit)
        bit_idx <= bit_idx + 3'd1;
      if (sample_bit)
        shift <= {sync2, shift[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/sap2_uart_loader.sv
// SAP-2 program loader: length-prefixed UART image written from address 0, CPU held until done.
// Optional trailing checksum byte enabled with `define LOADER_CHECKSUM_EN.
module sap2_uart_loader
  import sap2_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  logic              rx_valid, rx_ferr;
  logic [DATA_W-1:0] rx_byte;

  ld_state_t         ld_state, ld_next;
  logic [7:0]        len;
  logic [7:0]        seen;
  logic [ADDR_W-1:0] cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  sap2_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (CLK),
    .rst      (RST),
    .rxd      (RXD),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  // seen is a full 8-bit byte count so the end test works even when cnt wraps
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_WAIT_LEN:
        if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          ld_next = (rx_byte == 8'd0) ? LD_WAIT_SUM : LD_WAIT_DATA;
`else
          ld_next = (rx_byte == 8'd0) ? LD_DONE : LD_WAIT_DATA;
`endif
        end
      LD_WAIT_DATA:
        if (rx_valid) ld_next = LD_WRITE;
      LD_WRITE:
        if (seen + 8'd1 == len) begin
`ifdef LOADER_CHECKSUM_EN
          ld_next = LD_WAIT_SUM;
`else
          ld_next = LD_DONE;
`endif
        end else begin
          ld_next = LD_WAIT_DATA;
        end
`ifdef LOADER_CHECKSUM_EN
      LD_WAIT_SUM:
        if (rx_valid) ld_next = (sum + rx_byte == 8'd0) ? LD_DONE : LD_ERROR;
`endif
      LD_DONE:  ld_next = LD_DONE;
      LD_ERROR: ld_next = LD_ERROR;
      default:  ld_next = ld_state;
    endcase
    if (rx_ferr && ld_state != LD_DONE)
      ld_next = LD_ERROR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ld_state <= LD_WAIT_LEN;
      len      <= '0;
      seen     <= '0;
      cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      CPU_HOLD <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ld_state <= ld_next;
      if (ld_state == LD_WAIT_LEN && rx_valid) begin
        len  <= rx_byte;
        seen <= '0;
        cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum  <= rx_byte;
`endif
      end
      if (ld_state == LD_WAIT_DATA && ld_next == LD_WRITE) begin
        MEM_DATA <= rx_byte;
        MEM_ADDR <= cnt;
`ifdef LOADER_CHECKSUM_EN
        sum      <= sum + rx_byte;
`endif
      end
      if (ld_state == LD_WRITE) begin
        seen <= seen + 8'd1;
        cnt  <= cnt + ADDR_W'(1);
      end
      // outputs are registered decodes of the state being entered
      MEM_WE   <= (ld_next == LD_WRITE);
      CPU_HOLD <= (ld_next != LD_DONE);
      DONE     <= (ld_next == LD_DONE);
      ERR      <= (ld_next == LD_ERROR);
    end
  end

endmodule

// File: tb/tb_sap2_uart_loader.sv
// Self-checking bench for sap2_uart_loader: byte-level image model, per-cycle write/flag checks,
// plus literal expectations for the directed scenarios.
module tb_sap2_uart_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RXD = 1'b1;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_DATA;
  logic          CPU_HOLD;
  logic          DONE;
  logic          ERR;

  sap2_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXD      (RXD),
    .MEM_WE   (MEM_WE),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DATA (MEM_DATA),
    .CPU_HOLD (CPU_HOLD),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  wr_t  exp_q[$];
  int   log_addr[$];
  int   log_data[$];
  logic [7:0] img[0:15];
  int   bad_idx = -1;
  bit   exp_done, exp_err;
  int   last_we_cyc   = -100;
  int   done_rise_cyc = -1;
  bit   prev_done = 1'b0;
  bit   prev_err  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Per-cycle compare: every write must match the next model write; flags must be consistent.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (MEM_WE) begin
        log_addr.push_back(int'(MEM_ADDR));
        log_data.push_back(int'(MEM_DATA));
        last_we_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("we_addr", MEM_ADDR, w.addr);
          chk("we_data", MEM_DATA, w.data);
        end
      end
      chk("hold_vs_done", CPU_HOLD, !DONE);
      if (prev_done) chk("done_sticky", DONE, 1);
      if (prev_err)  chk("err_sticky", ERR, 1);
      if (DONE && !prev_done) done_rise_cyc = cyc;
      prev_done = DONE;
      prev_err  = ERR;
    end
  end

  // Byte-level loader model: length byte, data bytes, optional checksum byte.
  task automatic model_image(input int n);
    int k = 0;
    int len = 0;
    int sum = 0;
    bit d = 1'b0;
    bit e = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (d || e) continue;
      if (i == bad_idx) begin
        e = 1'b1;
        continue;
      end
      if (k == 0) begin
        len = int'(img[i]);
        sum = int'(img[i]);
        if (len == 0 && !CKS) d = 1'b1;
      end else if (k <= len) begin
        exp_q.push_back('{addr: (k - 1) % (1 << AW), data: int'(img[i])});
        sum += int'(img[i]);
        if (k == len && !CKS) d = 1'b1;
      end else begin
        d = ((sum + int'(img[i])) % 256) == 0;
        e = !d;
      end
      k++;
    end
    exp_done = d;
    exp_err  = e;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_image(input int n);
    model_image(n);
    for (int i = 0; i < n; i++) send_byte(img[i], i != bad_idx);
    repeat (12) @(negedge CLK);
    chk("writes_drained", exp_q.size(), 0);
    chk("done", DONE, exp_done);
    chk("err", ERR, exp_err);
    chk("cpu_hold", CPU_HOLD, !exp_done);
    exp_q.delete();
  endtask

  // Assert RST between clock edges; outputs must already be at reset values.
  task automatic do_reset(input string name);
    RST = 1'b1;
    #1;
    chk(name, {MEM_WE, MEM_ADDR, MEM_DATA, CPU_HOLD, DONE, ERR}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    repeat (2) @(negedge CLK);
    RXD = 1'b1;
    RST = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int ea[3];
    int ed[3];
    ea = '{0, 1, 2};
    ed = '{'hA1, 'hB2, 'hC3};

    repeat (3) @(negedge CLK);
    chk("reset_values", {MEM_WE, MEM_ADDR, MEM_DATA, CPU_HOLD, DONE, ERR}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Three-byte image
    img[0] = 8'h03; img[1] = 8'hA1; img[2] = 8'hB2; img[3] = 8'hC3;
    log_addr.delete();
    log_data.delete();
    run_image(4);
    chk("t1_nwrites", log_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        chk("t1_addr", log_addr[i], ea[i]);
        chk("t1_data", log_data[i], ed[i]);
      end
    end
`ifndef LOADER_CHECKSUM_EN
    chk("t1_done_lit", DONE, 1);
    chk("t1_done_after_last_we", done_rise_cyc - last_we_cyc, 1);
`endif
    do_reset("async_reset_after_done");

    // Zero-length image, trailing byte ignored
    img[0] = 8'h00; img[1] = 8'h99;
    log_addr.delete();
    run_image(2);
    chk("t2_nwrites", log_addr.size(), 0);
`ifndef LOADER_CHECKSUM_EN
    chk("t2_done_lit", DONE, 1);
`endif
    do_reset("reset_after_len0");

    // Framing error on the first data byte, later bytes ignored
    img[0] = 8'h02; img[1] = 8'h55; img[2] = 8'h01; img[3] = 8'h77;
    bad_idx = 1;
    log_addr.delete();
    run_image(4);
    bad_idx = -1;
    chk("t3_err_lit", ERR, 1);
    chk("t3_nwrites", log_addr.size(), 0);
    do_reset("reset_after_err");

    // One-cycle glitch must be rejected as a false start
    RXD = 1'b0;
    @(negedge CLK);
    RXD = 1'b1;
    repeat (10) @(negedge CLK);
    img[0] = 8'h01; img[1] = 8'h5A;
    log_addr.delete();
    log_data.delete();
    run_image(2);
    chk("t4_nwrites", log_addr.size(), 1);
    if (log_data.size() > 0) chk("t4_data_lit", log_data[0], 'h5A);
    do_reset("reset_after_glitch");

    // Reset during bit 5 of the first data byte
    img[0] = 8'h02;
    model_image(1);
    send_byte(8'h02, 1'b1);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RXD = img[0][0];
      RXD = (8'h11 >> i) & 8'h01;
      repeat (CPB) @(negedge CLK);
    end
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
    do_reset("async_reset_midframe");
    img[0] = 8'h01; img[1] = 8'h33;
    log_addr.delete();
    log_data.delete();
    run_image(2);
    chk("t5_nwrites", log_addr.size(), 1);
    if (log_data.size() > 0) chk("t5_data_lit", log_data[0], 'h33);

`ifdef LOADER_CHECKSUM_EN
    do_reset("reset_before_cks_good");
    img[0] = 8'h02; img[1] = 8'h10; img[2] = 8'h20; img[3] = 8'hCE;
    log_addr.delete();
    run_image(4);
    chk("cks_good_done_lit", DONE, 1);
    chk("cks_good_nwrites", log_addr.size(), 2);
    do_reset("reset_before_cks_bad");
    img[3] = 8'hCF;
    log_addr.delete();
    run_image(4);
    chk("cks_bad_err_lit", ERR, 1);
    chk("cks_bad_nwrites", log_addr.size(), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sap2_uart_loader.md
Name: sap2_uart_loader

Overview:
Upstream program loader for the SAP-2 core. It receives a program image over a UART 8N1 line on a dedicated input pin and writes it byte by byte into SAP-2 memory from address 0. It holds the CPU in reset until the image is complete, then releases it. It sits between the chip pins and the core's memory write port and reset input.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per UART bit; must be at least 4 and even.
ADDR_W, 8, memory address width.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
RXD  in  1  UART receive line; idle high; asynchronous to CLK
MEM_WE  out  1  one-cycle memory write strobe
MEM_ADDR  out  ADDR_W  write address
MEM_DATA  out  8  write data
CPU_HOLD  out  1  held high to keep the core in reset; drives the core RST together with the chip reset
DONE  out  1  image loaded; sticky
ERR  out  1  framing or checksum error; sticky

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, CPU_HOLD=1, DONE=0, ERR=0. Loader FSM state is WAIT_LEN. RX FSM state is IDLE.
- RXD synchronizer: two flops, both reset to 1. All RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized high-to-low transition.
  - START: sample at CLKS_PER_BIT/2 cycles. If the line is high, it was a false start; return to IDLE with no byte. If low -> DATA.
  - DATA: sample 8 bits LSB-first, each one CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample one CLKS_PER_BIT later. If 1, assert an internal rx_valid for exactly one cycle with rx_byte. If 0, assert rx_ferr for one cycle.
  - After STOP, return to IDLE immediately. A new start bit is accepted right after the stop sample.
- Loader FSM states: WAIT_LEN, WAIT_DATA, WRITE, [WAIT_SUM], DONE, ERROR.
  - WAIT_LEN: on rx_valid, latch len = rx_byte and set cnt=0. If len==0 -> DONE (no writes). Otherwise -> WAIT_DATA.
  - WAIT_DATA: on rx_valid, load MEM_DATA=rx_byte and MEM_ADDR=cnt -> WRITE.
  - WRITE: MEM_WE=1 for exactly this one cycle, which is the cycle after rx_valid. Then cnt increments. If cnt+1==len -> DONE (or WAIT_SUM with checksum enabled). Else -> WAIT_DATA.
  - DONE: CPU_HOLD=0, DONE=1. Further RX bytes are ignored. Only RST leaves this state.
  - ERROR: ERR=1, CPU_HOLD=1. Only RST leaves this state.
- rx_ferr in any loader state other than DONE -> ERROR.
- Widths:
  - len is 8 bits and cnt is ADDR_W bits.
  - If ADDR_W < 8 and len > 2^ADDR_W, MEM_ADDR wraps modulo 2^ADDR_W. Later bytes overwrite earlier ones; this is not an error.
  - len=255 with ADDR_W=8 writes addresses 0..254.
- MEM_ADDR and MEM_DATA hold their last value outside WRITE.
- RST mid-frame: everything returns to reset values immediately. A partially received byte is discarded. Memory contents already written are not cleared.
- CPU_HOLD is registered. There are no combinational paths from RXD to any output.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last data byte the FSM enters WAIT_SUM and waits for one more byte. If (sum of len, all data bytes and this byte) mod 256 == 0 -> DONE; otherwise -> ERROR. With len==0, WAIT_LEN also goes to WAIT_SUM, and the check covers only len and the checksum byte.
- Undefined: no WAIT_SUM state and no checksum byte; a byte arriving after DONE is ignored.

Decomposition:
- Package sap2_loader_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP
  - ld_state_t enum: WAIT_LEN, WAIT_DATA, WRITE, WAIT_SUM, DONE, ERROR
  - localparam for the 8-bit data width
- One sub-module, sap2_uart_rx: synchronizer, RX FSM and bit counter. Outputs rx_valid, rx_byte and rx_ferr. The loader FSM stays in the top module.

Test Plan:
- CLKS_PER_BIT=4, ADDR_W=8. Send 0x03, 0xA1, 0xB2, 0xC3 -> exactly three single-cycle MEM_WE pulses with (addr, data) = (0,A1), (1,B2), (2,C3). CPU_HOLD drops and DONE rises the cycle after the third pulse.
- Send 0x00 -> no MEM_WE pulses; DONE=1 and CPU_HOLD=0 after that byte's stop bit.
- Send 0x02, then a byte with stop bit 0 -> ERR=1, CPU_HOLD=1, no MEM_WE pulses. Subsequent valid bytes have no effect until RST.
- Glitch RXD low for 1 cycle while in IDLE -> no rx_valid. Then send 0x01, 0x5A -> one write of (0,5A).
- Assert RST during the 5th data bit of the second byte of 0x02, 0x11, 0x22 -> outputs return to reset values asynchronously. A fresh 0x01, 0x33 then writes (0,33).
- With LOADER_CHECKSUM_EN: send 0x02, 0x10, 0x20, 0xCE -> DONE. Send 0x02, 0x10, 0x20, 0xCF -> ERR=1. Both cases show two writes before the checksum byte is received.
